// File: rtl/mem_pkg.sv
// mem_pkg: shared FSM state type, width defaults and wait-counter width for mem_port_ctrl
package mem_pkg;
    localparam int ADDR_W_DEF = 11;
    localparam int DATA_W_DEF = 32;
    localparam int CNT_W      = 8;
    typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RSP} state_e;
endpackage

// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl: single-outstanding request/response bridge onto a split read/write memory port
//   clk, resetn            : rising-edge clock, asynchronous active-low reset
//   req_valid/ready/we/adrs/wdata : upstream request channel (accepted only in IDLE)
//   rsp_valid/ready/rdata/err     : response channel, held stable until consumed
//   mem_w_en/mem_w_adrs/mem_data_in, mem_r_en1/mem_r_adrs1 : registered memory command outputs
//   mem_w_valid1/mem_r_valid1/mem_data_out1                : memory completion strobes and read data
//   Optional macro MEM_PORT_TIMEOUT_EN enables a wait-state timeout that answers with rsp_err=1.
module mem_port_ctrl
    import mem_pkg::*;
#(
    parameter int ADDR_W         = ADDR_W_DEF,
    parameter int DATA_W         = DATA_W_DEF,
    parameter int TIMEOUT_CYCLES = 15
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_adrs,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              mem_w_en,
    output logic              mem_r_en1,
    output logic [ADDR_W-1:0] mem_w_adrs,
    output logic [ADDR_W-1:0] mem_r_adrs1,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic              mem_w_valid1,
    input  logic              mem_r_valid1,
    input  logic [DATA_W-1:0] mem_data_out1
);
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be within 1..255");
    end

    state_e            state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              mem_w_en_q, mem_w_en_d;
    logic              mem_r_en1_q, mem_r_en1_d;
    logic [ADDR_W-1:0] mem_w_adrs_q, mem_w_adrs_d;
    logic [ADDR_W-1:0] mem_r_adrs1_q, mem_r_adrs1_d;
    logic [DATA_W-1:0] mem_data_in_q, mem_data_in_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              accept;
    logic              timeout;

    assign accept = req_valid & req_ready_q;

`ifdef MEM_PORT_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TMO = CNT_W'(TIMEOUT_CYCLES);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             in_wait;
    assign in_wait = state_q == RD_WAIT || state_q == WR_WAIT;
    // acceptance is the only way into a WAIT state, so it doubles as the clear-on-entry
    always_comb cnt_d = accept ? '0 : (in_wait && cnt_q != '1) ? cnt_q + 1'b1 : cnt_q;
    always_ff @(posedge clk or negedge resetn)
        if (!resetn) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    assign timeout = in_wait && cnt_q >= TMO;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        mem_w_en_d    = 1'b0;
        mem_r_en1_d   = 1'b0;
        mem_w_adrs_d  = mem_w_adrs_q;
        mem_r_adrs1_d = mem_r_adrs1_q;
        mem_data_in_d = mem_data_in_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        case (state_q)
            IDLE: if (accept) begin
                state_d     = req_we ? WR_WAIT : RD_WAIT;
                mem_w_en_d  = req_we;
                mem_r_en1_d = !req_we;
                if (req_we) begin
                    mem_w_adrs_d  = req_adrs;
                    mem_data_in_d = req_wdata;
                end else begin
                    mem_r_adrs1_d = req_adrs;
                end
            end
            // a real completion wins over a timeout landing in the same cycle
            RD_WAIT: if (mem_r_valid1 || timeout) begin
                state_d     = RSP;
                rsp_rdata_d = mem_r_valid1 ? mem_data_out1 : '0;
                rsp_err_d   = !mem_r_valid1;
            end
            WR_WAIT: if (mem_w_valid1 || timeout) begin
                state_d     = RSP;
                rsp_rdata_d = '0;
                rsp_err_d   = !mem_w_valid1;
            end
            RSP: if (rsp_ready) state_d = IDLE;
        endcase
        // registered so ready stays low through reset and rises on the first edge after release
        req_ready_d = state_d == IDLE;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            req_ready_q   <= 1'b0;
            mem_w_en_q    <= 1'b0;
            mem_r_en1_q   <= 1'b0;
            mem_w_adrs_q  <= '0;
            mem_r_adrs1_q <= '0;
            mem_data_in_q <= '0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_ready_q   <= req_ready_d;
            mem_w_en_q    <= mem_w_en_d;
            mem_r_en1_q   <= mem_r_en1_d;
            mem_w_adrs_q  <= mem_w_adrs_d;
            mem_r_adrs1_q <= mem_r_adrs1_d;
            mem_data_in_q <= mem_data_in_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
        end
    end

    assign req_ready   = req_ready_q;
    assign rsp_valid   = state_q == RSP;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign mem_w_en    = mem_w_en_q;
    assign mem_r_en1   = mem_r_en1_q;
    assign mem_w_adrs  = mem_w_adrs_q;
    assign mem_r_adrs1 = mem_r_adrs1_q;
    assign mem_data_in = mem_data_in_q;
endmodule

// File: tb/tb_mem_port_ctrl.sv
// tb_mem_port_ctrl: table-driven and randomized checks of mem_port_ctrl against a memory model and reference array
module tb_mem_port_ctrl;
    localparam int TMO = 4;
`ifdef MEM_PORT_TIMEOUT_EN
    localparam int MAXLAT = 2;
`else
    localparam int MAXLAT = 6;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        req_valid, req_ready, req_we;
    logic [10:0] req_adrs;
    logic [31:0] req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        mem_w_en, mem_r_en1;
    logic [10:0] mem_w_adrs, mem_r_adrs1;
    logic [31:0] mem_data_in, mem_data_out1;
    logic        mem_w_valid1, mem_r_valid1;

    logic        fire_r, fire_w, stray_r, stray_w, dead;
    int          lat;
    logic [31:0] mem     [2048];
    logic [31:0] ref_mem [2048];
    int          n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    assign mem_r_valid1 = fire_r | stray_r;
    assign mem_w_valid1 = fire_w | stray_w;

    mem_port_ctrl #(.ADDR_W(11), .DATA_W(32), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .resetn(resetn),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_adrs(req_adrs), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .mem_w_en(mem_w_en), .mem_r_en1(mem_r_en1),
        .mem_w_adrs(mem_w_adrs), .mem_r_adrs1(mem_r_adrs1), .mem_data_in(mem_data_in),
        .mem_w_valid1(mem_w_valid1), .mem_r_valid1(mem_r_valid1), .mem_data_out1(mem_data_out1)
    );

    // memory model: sees an enable at a falling edge, answers 'lat' cycles after the next cycle
    initial begin
        bit r_pend, w_pend;
        int r_cnt, w_cnt;
        logic [10:0] r_a;
        r_pend = 0; w_pend = 0; r_cnt = 0; w_cnt = 0; r_a = '0;
        fire_r = 0; fire_w = 0; mem_data_out1 = 32'hA5A5A5A5;
        forever begin
            @(negedge clk);
            fire_r = 0; fire_w = 0;
            if (r_pend) begin
                if (r_cnt == 0) begin fire_r = 1; mem_data_out1 = mem[r_a]; r_pend = 0; end
                else r_cnt--;
            end
            if (w_pend) begin
                if (w_cnt == 0) begin fire_w = 1; w_pend = 0; end
                else w_cnt--;
            end
            if (mem_r_en1 && !dead) begin r_pend = 1; r_cnt = lat; r_a = mem_r_adrs1; end
            if (mem_w_en && !dead) begin w_pend = 1; w_cnt = lat; mem[mem_w_adrs] = mem_data_in; end
        end
    end

    task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [95:0] all_outs();
        return {5'd0, req_ready, rsp_valid, rsp_rdata, rsp_err, mem_w_en, mem_r_en1,
                mem_w_adrs, mem_r_adrs1, mem_data_in};
    endfunction

    // one complete transaction, launched at a falling edge while IDLE
    task automatic do_txn(input logic we, input logic [10:0] a, input logic [31:0] d, input int l,
                          input int hold, input int stray, input logic [31:0] exp_d,
                          input logic exp_e, input int exp_lat);
        int cyc, en_cnt, oth_cnt;
        bit got;
        lat = l;
        chk("ready_before_req", req_ready, 1);
        req_valid = 1; req_we = we; req_adrs = a; req_wdata = d;
        cyc = 0; en_cnt = 0; oth_cnt = 0; got = 0;
        while (!got && cyc < 300) begin
            @(negedge clk);
            cyc++;
            stray_r = 0; stray_w = 0;
            if (cyc == stray) begin
                if (we) stray_r = 1;
                else    stray_w = 1;
            end
            if (we ? mem_w_en : mem_r_en1) en_cnt++;
            if (we ? mem_r_en1 : mem_w_en) oth_cnt++;
            if (cyc == 1) begin
                chk("en_at_n1", we ? mem_w_en : mem_r_en1, 1);
                chk("adrs_at_n1", we ? mem_w_adrs : mem_r_adrs1, a);
                if (we) chk("wdata_at_n1", mem_data_in, d);
                chk("ready_low_busy", req_ready, 0);
                req_valid = 0; req_we = 1'($urandom); req_adrs = 11'($urandom); req_wdata = $urandom;
            end
            if (rsp_valid) got = 1;
        end
        stray_r = 0; stray_w = 0;
        chk("rsp_within_bound", got, 1);
        if (got) begin
            chk("rsp_latency", cyc, exp_lat);
            chk("single_en_pulse", en_cnt, 1);
            chk("no_other_en", oth_cnt, 0);
            chk("rsp_rdata", rsp_rdata, exp_d);
            chk("rsp_err", rsp_err, exp_e);
            chk("adrs_held", we ? mem_w_adrs : mem_r_adrs1, a);
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                chk("hold_valid", rsp_valid, 1);
                chk("hold_payload", {rsp_err, rsp_rdata}, {exp_e, exp_d});
                chk("hold_ready_low", req_ready, 0);
            end
            rsp_ready = 1;
            @(negedge clk);
            rsp_ready = 0;
            chk("rsp_done_idle", {rsp_valid, req_ready}, 2'b01);
        end
    endtask

    typedef struct {
        logic        we;
        logic [10:0] a;
        logic [31:0] d;
        int          lat;
        int          hold;
        int          stray;
        logic [31:0] exp_d;
    } vec_t;

    initial begin
        vec_t tbl [9];
        int nrsp;
        tbl[0] = '{1'b0, 11'h005, 32'h0,        0, 0, 0, 32'hDEADBEEF};
        tbl[1] = '{1'b1, 11'h7FF, 32'h12345678, 0, 0, 0, 32'h0};
        tbl[2] = '{1'b0, 11'h7FF, 32'h0,        0, 0, 0, 32'h12345678};
        tbl[3] = '{1'b1, 11'h000, 32'hCAFEF00D, 1, 0, 0, 32'h0};
        tbl[4] = '{1'b0, 11'h000, 32'h0,        2, 5, 0, 32'hCAFEF00D};
        tbl[5] = '{1'b1, 11'h2AA, 32'h0F0F0F0F, 2, 2, 0, 32'h0};
        tbl[6] = '{1'b0, 11'h2AA, 32'h0,        1, 0, 0, 32'h0F0F0F0F};
        tbl[7] = '{1'b1, 11'h555, 32'hFFFFFFFF, 0, 1, 1, 32'h0};
        tbl[8] = '{1'b0, 11'h555, 32'h0,        2, 0, 2, 32'hFFFFFFFF};

        for (int i = 0; i < 2048; i++) begin
            mem[i] = $urandom;
            ref_mem[i] = mem[i];
        end
        mem[5] = 32'hDEADBEEF; ref_mem[5] = 32'hDEADBEEF;
        stray_r = 0; stray_w = 0; dead = 0; lat = 0;
        req_valid = 0; req_we = 0; req_adrs = '0; req_wdata = '0; rsp_ready = 0;
        resetn = 1;
        #2 resetn = 0;
        #1 chk("reset_outs_zero", all_outs(), 96'd0);
        @(negedge clk);
        chk("reset_outs_zero_edge", all_outs(), 96'd0);
        resetn = 1;
        @(negedge clk);
        chk("ready_after_release", {req_ready, rsp_valid}, 2'b10);

        // strobes while idle must not produce a response
        stray_r = 1; stray_w = 1;
        @(negedge clk);
        stray_r = 0; stray_w = 0;
        chk("idle_stray_ignored", {rsp_valid, req_ready, mem_w_en, mem_r_en1}, 4'b0100);
        @(negedge clk);
        chk("idle_stray_ignored2", {rsp_valid, req_ready}, 2'b01);

        for (int i = 0; i < 9; i++) begin
            do_txn(tbl[i].we, tbl[i].a, tbl[i].d, tbl[i].lat, tbl[i].hold, tbl[i].stray,
                   tbl[i].exp_d, 1'b0, 3 + tbl[i].lat);
            if (tbl[i].we) ref_mem[tbl[i].a] = tbl[i].d;
        end

`ifdef MEM_PORT_TIMEOUT_EN
        dead = 1;
        do_txn(1'b0, 11'h0AB, 32'h0, 0, 1, 0, 32'h0, 1'b1, TMO + 2);
        do_txn(1'b1, 11'h0AB, 32'h11112222, 0, 0, 0, 32'h0, 1'b1, TMO + 2);
        dead = 0;
`else
        dead = 1; lat = 0;
        req_valid = 1; req_we = 0; req_adrs = 11'h123;
        @(negedge clk);
        req_valid = 0;
        nrsp = 0;
        repeat (100) begin
            @(negedge clk);
            if (rsp_valid) nrsp++;
        end
        chk("no_rsp_100_cycles", nrsp, 0);
        chk("ready_low_waiting", req_ready, 0);
        resetn = 0;
        @(negedge clk);
        resetn = 1;
        @(negedge clk);
        chk("ready_after_dead_reset", req_ready, 1);
        dead = 0;
`endif

        // reset in RD_WAIT, with the memory strobing only after release
        lat = 5;
        req_valid = 1; req_we = 0; req_adrs = 11'h005;
        @(negedge clk);
        req_valid = 0;
        chk("mid_rd_en", mem_r_en1, 1);
        @(negedge clk);
        resetn = 0;
        #1 chk("mid_reset_outs_zero", all_outs(), 96'd0);
        @(negedge clk);
        chk("mid_reset_outs_zero_edge", all_outs(), 96'd0);
        resetn = 1;
        @(negedge clk);
        chk("mid_ready_after_release", {req_ready, rsp_valid}, 2'b10);
        nrsp = 0;
        repeat (8) begin
            @(negedge clk);
            if (rsp_valid || !req_ready) nrsp++;
        end
        chk("late_strobe_ignored", nrsp, 0);

        for (int i = 0; i < 40; i++) begin
            logic        we;
            logic [10:0] a;
            logic [31:0] d, e;
            int          l, h;
            we = 1'($urandom);
            a  = $urandom_range(0, 1) ? {8'h3C, 3'($urandom)} : 11'($urandom);
            d  = $urandom;
            l  = $urandom_range(0, MAXLAT);
            h  = $urandom_range(0, 2);
            e  = we ? 32'h0 : ref_mem[a];
            do_txn(we, a, d, l, h, 0, e, 1'b0, 3 + l);
            if (we) ref_mem[a] = d;
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
